id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  Decode->Execute pipeline register of the 5-stage RV32I core. Captures the decoded control
//  bundle (ALUCtl, ResultSrc, Branch, Jump, MemWrite, ALUSrc, RegWrite) and the decode-stage
//  operands each cycle, then presents them to the Execute stage. Supports hazard-unit stall
//  (hold) and flush (bubble insert), and tracks a per-slot valid bit.
// PARAMETERS
//  XLEN      32  datapath width (PC, operands, immediate)
//  REGADDR_W  5  register-index width
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     synchronous, active-high reset
//  stall_e       in   1     hold current contents (from hazard unit)
//  flush_e       in   1     insert bubble (branch redirect / load-use)
//  valid_d       in   1     decode slot holds a real instruction
//  alu_ctl_d     in   4     ALU operation from control decode
//  result_src_d  in   2     writeback mux select
//  branch_d      in   1     conditional branch
//  jump_d        in   1     JAL/JALR
//  mem_write_d   in   1     store
//  alu_src_d     in   1     ALU B = immediate
//  reg_write_d   in   1     writes rd
//  rd1_d, rd2_d  in   XLEN  register-file read data
//  pc_d, pc_plus4_d in XLEN PC and PC+4 of decode instruction
//  imm_ext_d     in   XLEN  sign-extended immediate
//  rs1_d, rs2_d, rd_d in REGADDR_W register indices
//  *_e           out  same  registered copy of every *_d input above (incl. valid_e)
//  bubble_cnt    out  32    bubbles inserted (ID_EX_PERF_EN only)
//  stall_cnt     out  32    stall cycles held (ID_EX_PERF_EN only)
// BEHAVIOUR
//  - Priority per rising edge: rst > flush_e > stall_e > load.
//  - rst: every *_e output = 0 (valid_e=0, rd_e=0, all control 0 == architectural NOP).
//  - flush_e=1: same zero state as reset (bubble); applies even if stall_e=1 in same cycle.
//  - stall_e=1, flush_e=0: all *_e hold previous value; inputs ignored.
//  - otherwise: all *_e <= *_d; latency exactly 1 cycle, no combinational D->E path.
//  - valid_d=0 loaded normally: store-enables are forced off — reg_write_e, mem_write_e,
//    branch_e, jump_e = 0; datapath fields still copied (debug visibility).
//  - Outputs never X after first reset edge; no internal state beyond the registers.
//  - Reset asserted mid-stall or mid-flush: reset wins that edge; stall/flush resume on
//    following edges with normal priority.
// CONFIGURATION
//  ID_EX_PERF_EN defined: two 32-bit counters, reset to 0 by rst.
//   bubble_cnt +1 on each edge with flush_e=1 (and rst=0); stall_cnt +1 on each edge with
//   stall_e=1, flush_e=0, rst=0. Both wrap 0xFFFF_FFFF -> 0 silently.
//  Not defined: counters and ports bubble_cnt/stall_cnt do not exist; no other change.
// STRUCTURE
//  Package riscv_pkg: XLEN, REGADDR_W, typedef ctrl_bundle_t {alu_ctl[3:0], result_src[1:0],
//   branch, jump, mem_write, alu_src, reg_write}, constant CTRL_NOP = '0, ResultSrc encodings.
//  One sub-module: pipe_reg #(W) — W-bit register with sync clear (rst|flush) and enable
//   (!stall); instantiated for ctrl bundle and for packed datapath bundle.
// TESTING
//  1 rst=1 two cycles, inputs random -> all *_e = 0, valid_e=0, counters 0.
//  2 load add x3,x1,x2: alu_ctl_d=0, reg_write_d=1, rd_d=3, rd1_d=5, rd2_d=7, valid_d=1
//    -> next edge rd_e=3, reg_write_e=1, rd1_e=5, rd2_e=7, valid_e=1.
//  3 stall_e=1 for 3 cycles while *_d changes to rd_d=9 -> *_e stays rd_e=3; release ->
//    rd_e=9 one edge later; stall_cnt=3 (PERF_EN).
//  4 flush_e=1 and stall_e=1 same cycle with mem_write_d=1 -> mem_write_e=0, reg_write_e=0,
//    valid_e=0; bubble_cnt +1, stall_cnt unchanged.
//  5 valid_d=0, reg_write_d=1, mem_write_d=1, pc_d=0x100 -> reg_write_e=0, mem_write_e=0,
//    pc_e=0x100.
//  6 PERF_EN: preload via 2^32-1 flushes (force counter) then one flush -> bubble_cnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline: widths, the decoded control bundle and the
// packed decode->execute datapath bundle.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      imm_ext;
    logic [REGADDR_W-1:0] rs1;
    logic [REGADDR_W-1:0] rs2;
    logic [REGADDR_W-1:0] rd;
  } dp_bundle_t;

  // A slot without a real instruction must not change architectural state.
  function automatic ctrl_bundle_t gate_ctrl(input ctrl_bundle_t c, input logic valid);
    ctrl_bundle_t g;
    g = c;
    if (!valid) begin
      g.reg_write = 1'b0;
      g.mem_write = 1'b0;
      g.branch    = 1'b0;
      g.jump      = 1'b0;
    end else begin
      g = c;
    end
    return g;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_pipe_reg.sv
// Generic W-bit pipeline register with synchronous clear (highest priority) and load enable.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Clear beats enable so a bubble can be inserted while the stage is held.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= {W{1'b0}};
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode->Execute pipeline register with stall/flush and valid tracking.
// Optional ID_EX_PERF_EN adds bubble_cnt / stall_cnt performance counters.
module id_ex_stage_reg
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 valid_d,
  input  logic [3:0]           alu_ctl_d,
  input  logic [1:0]           result_src_d,
  input  logic                 branch_d,
  input  logic                 jump_d,
  input  logic                 mem_write_d,
  input  logic                 alu_src_d,
  input  logic                 reg_write_d,
  input  logic [XLEN-1:0]      rd1_d,
  input  logic [XLEN-1:0]      rd2_d,
  input  logic [XLEN-1:0]      pc_d,
  input  logic [XLEN-1:0]      pc_plus4_d,
  input  logic [XLEN-1:0]      imm_ext_d,
  input  logic [REGADDR_W-1:0] rs1_d,
  input  logic [REGADDR_W-1:0] rs2_d,
  input  logic [REGADDR_W-1:0] rd_d,
  output logic                 valid_e,
  output logic [3:0]           alu_ctl_e,
  output logic [1:0]           result_src_e,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic                 mem_write_e,
  output logic                 alu_src_e,
  output logic                 reg_write_e,
  output logic [XLEN-1:0]      rd1_e,
  output logic [XLEN-1:0]      rd2_e,
  output logic [XLEN-1:0]      pc_e,
  output logic [XLEN-1:0]      pc_plus4_e,
  output logic [XLEN-1:0]      imm_ext_e,
  output logic [REGADDR_W-1:0] rs1_e,
  output logic [REGADDR_W-1:0] rs2_e,
  output logic [REGADDR_W-1:0] rd_e
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]          bubble_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  ctrl_bundle_t ctrl_raw_s;
  ctrl_bundle_t ctrl_d_s;
  ctrl_bundle_t ctrl_e_s;
  dp_bundle_t   dp_d_s;
  dp_bundle_t   dp_e_s;
  logic         clr_s;
  logic         en_s;

  // Reset and flush both produce the all-zero NOP bubble.
  assign clr_s = rst | flush_e;
  assign en_s  = ~stall_e;

  assign ctrl_raw_s = '{alu_ctl: alu_ctl_d, result_src: result_src_d, branch: branch_d,
                        jump: jump_d, mem_write: mem_write_d, alu_src: alu_src_d,
                        reg_write: reg_write_d};
  assign ctrl_d_s   = gate_ctrl(ctrl_raw_s, valid_d);

  assign dp_d_s = '{valid: valid_d, rd1: rd1_d, rd2: rd2_d, pc: pc_d, pc_plus4: pc_plus4_d,
                    imm_ext: imm_ext_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d};

  pipe_reg #(.W($bits(ctrl_bundle_t))) u_ctrl_reg (
    .clk (clk),
    .clr (clr_s),
    .en  (en_s),
    .d   (ctrl_d_s),
    .q   (ctrl_e_s)
  );

  pipe_reg #(.W($bits(dp_bundle_t))) u_dp_reg (
    .clk (clk),
    .clr (clr_s),
    .en  (en_s),
    .d   (dp_d_s),
    .q   (dp_e_s)
  );

  assign alu_ctl_e    = ctrl_e_s.alu_ctl;
  assign result_src_e = ctrl_e_s.result_src;
  assign branch_e     = ctrl_e_s.branch;
  assign jump_e       = ctrl_e_s.jump;
  assign mem_write_e  = ctrl_e_s.mem_write;
  assign alu_src_e    = ctrl_e_s.alu_src;
  assign reg_write_e  = ctrl_e_s.reg_write;

  assign valid_e    = dp_e_s.valid;
  assign rd1_e      = dp_e_s.rd1;
  assign rd2_e      = dp_e_s.rd2;
  assign pc_e       = dp_e_s.pc;
  assign pc_plus4_e = dp_e_s.pc_plus4;
  assign imm_ext_e  = dp_e_s.imm_ext;
  assign rs1_e      = dp_e_s.rs1;
  assign rs2_e      = dp_e_s.rs2;
  assign rd_e       = dp_e_s.rd;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] stall_cnt_r;

  // A cycle that is both flushed and stalled counts only as a bubble; both wrap silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else if (flush_e) begin
      bubble_cnt_r <= bubble_cnt_r + 32'd1;
      stall_cnt_r  <= stall_cnt_r;
    end else if (stall_e) begin
      bubble_cnt_r <= bubble_cnt_r;
      stall_cnt_r  <= stall_cnt_r + 32'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
      stall_cnt_r  <= stall_cnt_r;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign stall_cnt  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vectors, a behavioural reference
// model compared every negedge, and hand-computed literal checks.
module tb_id_ex_stage_reg;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst, stall_e, flush_e, valid_d;
  logic [3:0] alu_ctl_d;
  logic [1:0] result_src_d;
  logic branch_d, jump_d, mem_write_d, alu_src_d, reg_write_d;
  logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
  logic [4:0] rs1_d, rs2_d, rd_d;

  logic valid_e;
  logic [3:0] alu_ctl_e;
  logic [1:0] result_src_e;
  logic branch_e, jump_e, mem_write_e, alu_src_e, reg_write_e;
  logic [31:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .alu_ctl_d(alu_ctl_d), .result_src_d(result_src_d), .branch_d(branch_d), .jump_d(jump_d),
    .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .valid_e(valid_e), .alu_ctl_e(alu_ctl_e), .result_src_e(result_src_e),
    .branch_e(branch_e), .jump_e(jump_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .reg_write_e(reg_write_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: the expected Execute-side slot, as a flat list of fields.
  logic [31:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu;
  logic [1:0]  m_rsrc;
  logic m_valid, m_br, m_jmp, m_mw, m_asrc, m_rw;
  logic [31:0] m_bub, m_stl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst || flush_e) begin
      {m_valid, m_alu, m_rsrc, m_br, m_jmp, m_mw, m_asrc, m_rw} <= '0;
      {m_rd1, m_rd2, m_pc, m_pc4, m_imm, m_rs1, m_rs2, m_rd} <= '0;
    end else if (!stall_e) begin
      m_valid <= valid_d;
      m_alu <= alu_ctl_d; m_rsrc <= result_src_d; m_asrc <= alu_src_d;
      m_br <= valid_d && branch_d;  m_jmp <= valid_d && jump_d;
      m_mw <= valid_d && mem_write_d; m_rw <= valid_d && reg_write_d;
      m_rd1 <= rd1_d; m_rd2 <= rd2_d; m_pc <= pc_d; m_pc4 <= pc_plus4_d; m_imm <= imm_ext_d;
      m_rs1 <= rs1_d; m_rs2 <= rs2_d; m_rd <= rd_d;
    end
    if (rst) begin
      m_bub <= 32'd0; m_stl <= 32'd0;
    end else begin
      if (flush_e) m_bub <= m_bub + 32'd1;
      if (stall_e && !flush_e) m_stl <= m_stl + 32'd1;
    end
  end

  // Compare every field against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_e", valid_e, m_valid);
      chk("alu_ctl_e", alu_ctl_e, m_alu);
      chk("result_src_e", result_src_e, m_rsrc);
      chk("branch_e", branch_e, m_br);
      chk("jump_e", jump_e, m_jmp);
      chk("mem_write_e", mem_write_e, m_mw);
      chk("alu_src_e", alu_src_e, m_asrc);
      chk("reg_write_e", reg_write_e, m_rw);
      chk("rd1_e", rd1_e, m_rd1);
      chk("rd2_e", rd2_e, m_rd2);
      chk("pc_e", pc_e, m_pc);
      chk("pc_plus4_e", pc_plus4_e, m_pc4);
      chk("imm_ext_e", imm_ext_e, m_imm);
      chk("rs1_e", rs1_e, m_rs1);
      chk("rs2_e", rs2_e, m_rs2);
      chk("rd_e", rd_e, m_rd);
`ifdef ID_EX_PERF_EN
      chk("bubble_cnt", bubble_cnt, m_bub);
      chk("stall_cnt", stall_cnt, m_stl);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    valid_d = 1'($urandom); alu_ctl_d = 4'($urandom); result_src_d = 2'($urandom);
    branch_d = 1'($urandom); jump_d = 1'($urandom); mem_write_d = 1'($urandom);
    alu_src_d = 1'($urandom); reg_write_d = 1'($urandom);
    rd1_d = $urandom; rd2_d = $urandom; pc_d = $urandom; pc_plus4_d = $urandom;
    imm_ext_d = $urandom; rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
  endtask

  task automatic clear_data();
    valid_d = 1'b0; alu_ctl_d = 4'd0; result_src_d = RESULT_SRC_ALU;
    branch_d = 1'b0; jump_d = 1'b0; mem_write_d = 1'b0; alu_src_d = 1'b0; reg_write_d = 1'b0;
    rd1_d = 32'd0; rd2_d = 32'd0; pc_d = 32'd0; pc_plus4_d = 32'd0; imm_ext_d = 32'd0;
    rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0;
  endtask

  initial begin
    // 1: reset for two cycles with random inputs
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rand_data();
    step();
    chk_en = 1'b1;
    rand_data();
    step();
    chk("rst rd_e", rd_e, 64'd0);
    chk("rst valid_e", valid_e, 64'd0);
    chk("rst reg_write_e", reg_write_e, 64'd0);
`ifdef ID_EX_PERF_EN
    chk("rst bubble_cnt", bubble_cnt, 64'd0);
    chk("rst stall_cnt", stall_cnt, 64'd0);
`endif

    // 2: add x3,x1,x2
    rst = 1'b0;
    clear_data();
    valid_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd3; rs1_d = 5'd1; rs2_d = 5'd2;
    rd1_d = 32'd5; rd2_d = 32'd7; pc_d = 32'h40; pc_plus4_d = 32'h44;
    step();
    chk("add rd_e", rd_e, 64'd3);
    chk("add reg_write_e", reg_write_e, 64'd1);
    chk("add rd1_e", rd1_e, 64'd5);
    chk("add rd2_e", rd2_e, 64'd7);
    chk("add valid_e", valid_e, 64'd1);

    // 3: stall three cycles while decode moves on
    stall_e = 1'b1;
    rd_d = 5'd9; rd1_d = 32'h11; pc_d = 32'h48;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall rd_e", rd_e, 64'd3);
      chk("stall rd1_e", rd1_e, 64'd5);
    end
    stall_e = 1'b0;
    step();
    chk("release rd_e", rd_e, 64'd9);
    chk("release pc_e", pc_e, 64'h48);
`ifdef ID_EX_PERF_EN
    chk("stall_cnt 3", stall_cnt, 64'd3);
`endif

    // 4: flush and stall together with a store in decode
    stall_e = 1'b1; flush_e = 1'b1; mem_write_d = 1'b1; valid_d = 1'b1;
    step();
    chk("flush mem_write_e", mem_write_e, 64'd0);
    chk("flush reg_write_e", reg_write_e, 64'd0);
    chk("flush valid_e", valid_e, 64'd0);
`ifdef ID_EX_PERF_EN
    chk("flush bubble_cnt", bubble_cnt, 64'd1);
    chk("flush stall_cnt", stall_cnt, 64'd3);
`endif

    // 5: invalid slot loads datapath but no store enables
    stall_e = 1'b0; flush_e = 1'b0;
    clear_data();
    valid_d = 1'b0; reg_write_d = 1'b1; mem_write_d = 1'b1; branch_d = 1'b1; jump_d = 1'b1;
    pc_d = 32'h100; alu_ctl_d = 4'd6;
    step();
    chk("inv reg_write_e", reg_write_e, 64'd0);
    chk("inv mem_write_e", mem_write_e, 64'd0);
    chk("inv branch_e", branch_e, 64'd0);
    chk("inv jump_e", jump_e, 64'd0);
    chk("inv pc_e", pc_e, 64'h100);
    chk("inv alu_ctl_e", alu_ctl_e, 64'd6);

    // reset arriving mid-stall wins, then stall holds the zero state
    valid_d = 1'b1; rd_d = 5'd12;
    stall_e = 1'b1; rst = 1'b1;
    step();
    chk("rst-in-stall rd_e", rd_e, 64'd0);
    rst = 1'b0;
    step();
    chk("post-rst stall rd_e", rd_e, 64'd0);
    stall_e = 1'b0;
    step();
    chk("post-rst load rd_e", rd_e, 64'd12);

    // mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      rand_data();
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 6) == 0);
      rst     = ($urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0; stall_e = 1'b0; flush_e = 1'b0;

`ifdef ID_EX_PERF_EN
    // 6: bubble counter wraps from all-ones to zero
    @(negedge clk);
    #1;
    force dut.bubble_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_r;
    m_bub = 32'hFFFF_FFFF;
    flush_e = 1'b1;
    step();
    flush_e = 1'b0;
    chk("wrap bubble_cnt", bubble_cnt, 64'd0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
